store_buffer_lsu: RTL
=====================

// Module: store_buffer_lsu
// PURPOSE
//  Load/store front end placed directly upstream of the 8-bit data memory.
//  Accepts pipeline load/store requests and queues stores in a small FIFO.
//  Drains stores to memory in port-idle cycles and forwards buffered data to loads.
//  Load misses go through the memory's registered read path.
// PARAMETERS
//  DEPTH   4  store-buffer entries (power of 2, >=2)
//  ADDR_W  8  address width
//  DATA_W  8  data width
// PORTS
//  clock      in   1       rising-edge clock
//  reset_n    in   1       synchronous, active-low reset
//  reqValid   in   1       request present
//  reqWrite   in   1       1=store, 0=load
//  reqAddr    in   ADDR_W  request address
//  reqData    in   DATA_W  store data
//  reqReady   out  1       request accepted at edge when reqValid&reqReady
//  respValid  out  1       one-cycle pulse: load data valid (no backpressure)
//  respData   out  DATA_W  load result
//  empty      out  1       store buffer empty (fence/drain status)
//  memRead    out  1       to memory read enable
//  memWrite   out  1       to memory write enable
//  memAddr    out  ADDR_W  to memory address
//  memData    out  DATA_W  to memory write data
//  memOut     in   DATA_W  memory registered read data (valid the cycle after memRead)
// BEHAVIOUR
//  Reset (reset_n low at edge): FSM=IDLE, head=tail=count=0, respValid=0,
//   respData=0, empty=1. Combinational outputs gated while reset_n low:
//   reqReady=0, memRead=0, memWrite=0. In-flight load and buffered stores are
//   discarded; no response is produced.
//  FSM: IDLE, LD_ISSUE, LD_WAIT.
//   IDLE -> LD_ISSUE on accepted load that misses the buffer; else stays IDLE.
//   LD_ISSUE (1 cycle): memRead=1, memAddr=latched load addr -> LD_WAIT.
//   LD_WAIT (1 cycle): respValid=1, respData=memOut -> IDLE.
//  reqReady = (state==IDLE) && !(reqWrite && count==DEPTH).
//  Store accept: enqueue {addr,data} at tail. Tail wraps modulo DEPTH.
//  Load accept: search all valid entries; youngest matching addr wins.
//   Hit: respValid=1 with forwarded data in the cycle after the accept edge
//   (latency 1). No memRead is issued.
//   Miss: memRead asserted in cycle +1; respValid in cycle +2 (latency 2).
//  Drain: when count>0 && state!=LD_ISSUE && (!reqValid || count==DEPTH),
//   drive memWrite=1, memAddr/memData=head entry. Head pops at the edge.
//   Drains are strictly oldest-first.
//  Simultaneous enqueue+drain: count unchanged, both pointers advance.
//   Forward search sees pre-edge contents, including the entry draining that
//   cycle.
//  memRead and memWrite are never both 1.
//  empty = (count==0), registered-consistent with count.
// STRUCTURE
//  Package lsu_pkg: ADDR_W/DATA_W defaults, FSM state enum, entry struct {addr,data}.
//  Sub-module store_buffer_fifo: circular storage, head/tail/count, parallel
//   youngest-match search (hit, hitData). Top level holds the FSM, drain
//   arbitration and memory-port muxing.
// TESTING (memory model preloaded word[100]=150)
//  1. reset_n low 2 cycles, reqValid=1 -> reqReady=0, memRead=memWrite=0,
//     respValid=0, empty=1.
//  2. Load addr 100 on empty buffer -> memRead=1 addr 100 next cycle;
//     respValid=1 respData=150 the cycle after; reqReady=0 during both.
//  3. Store 0x20@5, then load @5 next cycle -> respValid next cycle, data 0x20,
//     no memRead pulse.
//  4. Store 0x11@7, store 0x22@7, load @7 -> 0x22. After idle, memWrite pulses
//     in order 0x11, 0x22; a later load @7 miss returns 0x22.
//  5. Six back-to-back stores (addrs 1..6): after 4 accepts reqReady=0 and one
//     drain occurs; acceptance resumes; head/tail wrap; all six written in order.
//  6. Load miss @100 accepted, reset_n low during LD_ISSUE -> no respValid,
//     empty=1, FSM IDLE after reset release.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and default widths for the load/store unit front end.
package lsu_pkg;

   localparam int unsigned ADDR_W_DEF = 8;
   localparam int unsigned DATA_W_DEF = 8;
   localparam int unsigned DEPTH_DEF  = 4;

   typedef enum logic [1:0] {
      IDLE,
      LD_ISSUE,
      LD_WAIT
   } state_t;

   typedef struct packed {
      logic [ADDR_W_DEF-1:0] addr;
      logic [DATA_W_DEF-1:0] data;
   } entry_t;

endpackage

// File: rtl/store_buffer_fifo.sv
// Circular store buffer with head/tail/count and a parallel youngest-match
// address search used for store-to-load forwarding.
module store_buffer_fifo
   import lsu_pkg::*;
#(
   parameter int unsigned DEPTH  = DEPTH_DEF,
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     push,
   input  logic [ADDR_W-1:0]        pushAddr,
   input  logic [DATA_W-1:0]        pushData,
   input  logic                     pop,
   input  logic [ADDR_W-1:0]        searchAddr,
   output logic                     hit,
   output logic [DATA_W-1:0]        hitData,
   output logic [ADDR_W-1:0]        headAddr,
   output logic [DATA_W-1:0]        headData,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PW = $clog2(DEPTH);

   logic [ADDR_W-1:0] addrMem [DEPTH];
   logic [DATA_W-1:0] dataMem [DEPTH];
   logic [PW-1:0]     head;
   logic [PW-1:0]     tail;
   logic [PW-1:0]     idx;

   always_ff @(posedge clock) begin
      if (push) begin
         addrMem[tail] <= pushAddr;
         dataMem[tail] <= pushData;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) tail <= tail + 1'b1;
         if (pop)  head <= head + 1'b1;
         if (push && !pop)
            count <= count + 1'b1;
         else if (!push && pop)
            count <= count - 1'b1;
      end
   end

   assign headAddr = addrMem[head];
   assign headData = dataMem[head];

   // Walk oldest to youngest so the last match (youngest store) wins.
   always_comb begin
      hit     = 1'b0;
      hitData = '0;
      idx     = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         idx = head + PW'(i);
         if ((i < 32'(count)) && (addrMem[idx] == searchAddr)) begin
            hit     = 1'b1;
            hitData = dataMem[idx];
         end
      end
   end

endmodule

// File: rtl/store_buffer_lsu.sv
// Load/store front end: buffers stores, drains them in idle port cycles,
// forwards buffered data to loads and sends misses through the memory read path.
module store_buffer_lsu
   import lsu_pkg::*;
#(
   parameter int unsigned DEPTH  = DEPTH_DEF,
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              reqValid,
   input  logic              reqWrite,
   input  logic [ADDR_W-1:0] reqAddr,
   input  logic [DATA_W-1:0] reqData,
   output logic              reqReady,
   output logic              respValid,
   output logic [DATA_W-1:0] respData,
   output logic              empty,
   output logic              memRead,
   output logic              memWrite,
   output logic [ADDR_W-1:0] memAddr,
   output logic [DATA_W-1:0] memData,
   input  logic [DATA_W-1:0] memOut
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;

   state_t            state;
   logic [ADDR_W-1:0] ldAddr;
   logic [DATA_W-1:0] respHold;
   logic [CW-1:0]     count;
   logic              hit;
   logic [DATA_W-1:0] hitData;
   logic [ADDR_W-1:0] headAddr;
   logic [DATA_W-1:0] headData;
   logic              full;
   logic              accept;
   logic              push;
   logic              drain;

   assign full     = (count == CW'(DEPTH));
   assign reqReady = reset_n && (state == IDLE) && !(reqWrite && full);
   assign accept   = reqValid && reqReady;
   assign push     = accept && reqWrite;

   // A full buffer drains even under request pressure so stores can progress.
   assign drain    = reset_n && (count != '0) && (state != LD_ISSUE) &&
                     (!reqValid || full);

   assign memRead  = reset_n && (state == LD_ISSUE);
   assign memWrite = drain;
   assign memAddr  = (state == LD_ISSUE) ? ldAddr : headAddr;
   assign memData  = headData;
   assign empty    = (count == '0);
   assign respData = (state == LD_WAIT) ? memOut : respHold;

   store_buffer_fifo #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_fifo (
      .clock      (clock),
      .reset_n    (reset_n),
      .push       (push),
      .pushAddr   (reqAddr),
      .pushData   (reqData),
      .pop        (drain),
      .searchAddr (reqAddr),
      .hit        (hit),
      .hitData    (hitData),
      .headAddr   (headAddr),
      .headData   (headData),
      .count      (count)
   );

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state     <= IDLE;
         respValid <= 1'b0;
         respHold  <= '0;
         ldAddr    <= '0;
      end else begin
         respValid <= 1'b0;
         case (state)
            IDLE: begin
               if (accept && !reqWrite) begin
                  if (hit) begin
                     respValid <= 1'b1;
                     respHold  <= hitData;
                  end else begin
                     ldAddr <= reqAddr;
                     state  <= LD_ISSUE;
                  end
               end
            end
            LD_ISSUE: begin
               respValid <= 1'b1;
               state     <= LD_WAIT;
            end
            LD_WAIT: begin
               respHold <= memOut;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
